spoc64_ctrl: RTL and testbench

- Control FSM that sequences the SpoC-64 datapath through one AEAD operation: key/npub load, initialization permutation, AD absorb, message encrypt/decrypt, tag generation and tag verification.
- Drives every datapath enable/select and the permutation start/done handshake.
- Terminates the 32-bit LWC-style key/bdi/bdo stream handshakes.
- Sits between the pre/post-processor and the datapath. One operation in flight at a time.

---
 rtl/spoc64_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_spoc64_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spoc64_ctrl.sv
// SpoC-64 AEAD control FSM: sequences key/npub load, init permutation, AD absorb,
// message processing, tag generation/verification, and terminates the key/bdi/bdo streams.
module spoc64_ctrl #(
  parameter int PW        = 32,
  parameter int BLK_BYTES = 8,
  parameter int KEY_WORDS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_decrypt,
  input  logic       cmd_new_key,
  input  logic       cmd_empty_ad,
  input  logic       cmd_empty_msg,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       bdi_valid,
  output logic       bdi_ready,
  input  logic       bdi_eot,
  input  logic [3:0] bdi_type,
  input  logic [2:0] bdi_size,
  output logic       bdo_valid,
  input  logic       bdo_ready,
  output logic       auth_valid,
  output logic       auth,
  input  logic       perm_done,
  input  logic       trunc_complete,
  input  logic       dp_msg_auth,
  output logic       start,
  output logic       init_state,
  output logic       init_lock,
  output logic       en_key,
  output logic       en_npub,
  output logic       en_bdi,
  output logic       clr_bdi,
  output logic       en_cum_size,
  output logic       en_trunc,
  output logic       init_trunc,
  output logic       bdi_partial_reg,
  output logic       bdi_complete,
  output logic       bdo_complete,
  output logic       en_state_in,
  output logic       sel_tag,
  output logic       lock_tag_state,
  output logic       decrypt_reg,
  output logic [1:0] ctrl_word
);

  localparam logic [3:0] BLK_B   = 4'(BLK_BYTES);
  localparam logic [3:0] WORD_B  = 4'(PW / 8);
  localparam logic [1:0] KW_LAST = 2'(KEY_WORDS - 1);

  localparam logic [3:0] T_AD   = 4'b0001;
  localparam logic [3:0] T_MSG  = 4'b0100;
  localparam logic [3:0] T_TAG  = 4'b1000;

  typedef enum logic [4:0] {
    S_IDLE, S_LD_KEY, S_LD_NPUB, S_INIT, S_PERM, S_PERM_WAIT, S_ILOCK,
    S_AD_CLR, S_AD_RD, S_AD_ABS, S_MSG_CLR, S_MSG_RD, S_TRUNC_INIT, S_TRUNC,
    S_MSG_OUT, S_MSG_ABS, S_TAG, S_TAG_OUT, S_TAG_CLR, S_TAG_IN, S_AUTH
  } state_t;

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] blk_bytes_q, blk_bytes_d;
  logic       eot_q, eot_d;
  logic       dec_q, dec_d;
  logic       empty_ad_q, empty_ad_d;
  logic       empty_msg_q, empty_msg_d;

  logic       type_ok;
  logic       rd_fire;
  logic [3:0] blk_sum;
  logic       rd_last;

  // bdi_ready in the read states is gated by a phase/type match; a mismatch simply stalls.
  always_comb begin
    type_ok = ((state_q == S_AD_RD)  && (bdi_type == T_AD))  ||
              ((state_q == S_MSG_RD) && (bdi_type == T_MSG)) ||
              ((state_q == S_TAG_IN) && (bdi_type == T_TAG));
    rd_fire = bdi_valid && type_ok;
    blk_sum = blk_bytes_q + {1'b0, bdi_size};
    rd_last = cnt_q[0] || bdi_eot;
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    blk_bytes_d = blk_bytes_q;
    eot_d       = eot_q;
    dec_d       = dec_q;
    empty_ad_d  = empty_ad_q;
    empty_msg_d = empty_msg_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dec_d       = cmd_decrypt;
          empty_ad_d  = cmd_empty_ad;
          empty_msg_d = cmd_empty_msg;
          cnt_d       = '0;
          state_d     = cmd_new_key ? S_LD_KEY : S_LD_NPUB;
        end
      end
      S_LD_KEY: begin
        if (key_valid) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == KW_LAST) state_d = S_LD_NPUB;
        end
      end
      S_LD_NPUB: begin
        if (bdi_valid) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == KW_LAST) state_d = S_INIT;
        end
      end
      S_INIT: begin
        state_d = S_PERM;
        ret_d   = S_ILOCK;
      end
      S_PERM:      state_d = S_PERM_WAIT;
      S_PERM_WAIT: if (perm_done) state_d = ret_q;
      S_ILOCK: begin
        if (!empty_ad_q)       state_d = S_AD_CLR;
        else if (!empty_msg_q) state_d = S_MSG_CLR;
        else                   state_d = S_TAG;
      end
      S_AD_CLR, S_MSG_CLR: begin
        cnt_d       = '0;
        blk_bytes_d = '0;
        eot_d       = 1'b0;
        state_d     = (state_q == S_AD_CLR) ? S_AD_RD : S_MSG_RD;
      end
      S_AD_RD, S_MSG_RD: begin
        if (rd_fire) begin
          blk_bytes_d = blk_sum;
          eot_d       = bdi_eot;
          cnt_d       = {1'b0, ~cnt_q[0]};
          if (rd_last) begin
            cnt_d = '0;
            if (state_q == S_AD_RD)  state_d = S_AD_ABS;
            else if (blk_sum < BLK_B) state_d = S_TRUNC_INIT;
            else                      state_d = S_MSG_OUT;
          end
        end
      end
      S_AD_ABS: begin
        state_d = S_PERM;
        if (!eot_q)            ret_d = S_AD_CLR;
        else if (!empty_msg_q) ret_d = S_MSG_CLR;
        else                   ret_d = S_TAG;
      end
      S_TRUNC_INIT: state_d = S_TRUNC;
      S_TRUNC:      if (trunc_complete) state_d = S_MSG_OUT;
      S_MSG_OUT: begin
        if (bdo_ready) begin
          if (!cnt_q[0] && (blk_bytes_q > WORD_B)) begin
            cnt_d = 2'd1;
          end else begin
            cnt_d   = '0;
            state_d = S_MSG_ABS;
          end
        end
      end
      S_MSG_ABS: begin
        state_d = S_PERM;
        ret_d   = eot_q ? S_TAG : S_MSG_CLR;
      end
      S_TAG: begin
        state_d = S_PERM;
        ret_d   = dec_q ? S_TAG_CLR : S_TAG_OUT;
        cnt_d   = '0;
      end
      S_TAG_OUT: begin
        if (bdo_ready) begin
          if (!cnt_q[0]) begin
            cnt_d = 2'd1;
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_TAG_CLR: begin
        cnt_d   = '0;
        state_d = S_TAG_IN;
      end
      S_TAG_IN: begin
        if (rd_fire) begin
          if (cnt_q[0]) begin
            cnt_d   = '0;
            state_d = S_AUTH;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      S_AUTH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      cnt_q       <= '0;
      blk_bytes_q <= '0;
      eot_q       <= 1'b0;
      dec_q       <= 1'b0;
      empty_ad_q  <= 1'b0;
      empty_msg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      blk_bytes_q <= blk_bytes_d;
      eot_q       <= eot_d;
      dec_q       <= dec_d;
      empty_ad_q  <= empty_ad_d;
      empty_msg_q <= empty_msg_d;
    end
  end

  // Controls decode from the registered state; enables tied to a handshake add the valid term.
  assign cmd_ready       = (state_q == S_IDLE);
  assign key_ready       = (state_q == S_LD_KEY);
  assign en_key          = key_ready && key_valid;
  assign bdi_ready       = (state_q == S_LD_NPUB) || type_ok;
  assign en_npub         = (state_q == S_LD_NPUB) && bdi_valid;
  assign clr_bdi         = (state_q == S_AD_CLR) || (state_q == S_MSG_CLR) || (state_q == S_TAG_CLR);
  assign en_bdi          = clr_bdi || rd_fire;
  assign en_cum_size     = (state_q == S_AD_CLR) || (state_q == S_MSG_CLR) ||
                           (rd_fire && (state_q != S_TAG_IN));
  assign bdi_complete    = rd_fire && cnt_q[0];
  assign start           = (state_q == S_PERM);
  assign init_state      = (state_q == S_INIT);
  assign init_lock       = (state_q == S_ILOCK);
  assign lock_tag_state  = (state_q == S_TAG);
  assign en_state_in     = (state_q == S_INIT) || (state_q == S_ILOCK) || (state_q == S_AD_ABS) ||
                           (state_q == S_MSG_ABS) || (state_q == S_TAG);
  assign ctrl_word       = {state_q == S_MSG_ABS, state_q == S_AD_ABS};
  assign bdi_partial_reg = ((state_q == S_AD_ABS) || (state_q == S_MSG_ABS)) && (blk_bytes_q < BLK_B);
  assign init_trunc      = (state_q == S_TRUNC_INIT);
  assign en_trunc        = (state_q == S_TRUNC);
  assign bdo_valid       = (state_q == S_MSG_OUT) || (state_q == S_TAG_OUT);
  assign bdo_complete    = bdo_valid && cnt_q[0];
  assign sel_tag         = (state_q == S_TAG_OUT);
  assign auth_valid      = (state_q == S_AUTH);
  assign auth            = auth_valid && dp_msg_auth;
  assign decrypt_reg     = dec_q;

endmodule

// File: tb/tb_spoc64_ctrl.sv
// Randomized bench for spoc64_ctrl: drives whole AEAD operations and compares per-operation
// event counts against lengths-derived expectations.
module tb_spoc64_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_decrypt, cmd_new_key, cmd_empty_ad, cmd_empty_msg;
  logic       key_valid, key_ready;
  logic       bdi_valid, bdi_ready, bdi_eot;
  logic [3:0] bdi_type;
  logic [2:0] bdi_size;
  logic       bdo_valid, bdo_ready;
  logic       auth_valid, auth;
  logic       perm_done, trunc_complete, dp_msg_auth;
  logic       start, init_state, init_lock, en_key, en_npub, en_bdi, clr_bdi, en_cum_size;
  logic       en_trunc, init_trunc, bdi_partial_reg, bdi_complete, bdo_complete, en_state_in;
  logic       sel_tag, lock_tag_state, decrypt_reg;
  logic [1:0] ctrl_word;

  spoc64_ctrl #(.PW(32), .BLK_BYTES(8), .KEY_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_decrypt(cmd_decrypt),
    .cmd_new_key(cmd_new_key), .cmd_empty_ad(cmd_empty_ad), .cmd_empty_msg(cmd_empty_msg),
    .key_valid(key_valid), .key_ready(key_ready),
    .bdi_valid(bdi_valid), .bdi_ready(bdi_ready), .bdi_eot(bdi_eot),
    .bdi_type(bdi_type), .bdi_size(bdi_size),
    .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
    .auth_valid(auth_valid), .auth(auth),
    .perm_done(perm_done), .trunc_complete(trunc_complete), .dp_msg_auth(dp_msg_auth),
    .start(start), .init_state(init_state), .init_lock(init_lock), .en_key(en_key),
    .en_npub(en_npub), .en_bdi(en_bdi), .clr_bdi(clr_bdi), .en_cum_size(en_cum_size),
    .en_trunc(en_trunc), .init_trunc(init_trunc), .bdi_partial_reg(bdi_partial_reg),
    .bdi_complete(bdi_complete), .bdo_complete(bdo_complete), .en_state_in(en_state_in),
    .sel_tag(sel_tag), .lock_tag_state(lock_tag_state), .decrypt_reg(decrypt_reg),
    .ctrl_word(ctrl_word)
  );

  always #5 clk = ~clk;

  logic [23:0] outs;
  assign outs = {start, init_state, init_lock, en_key, en_npub, en_bdi, clr_bdi, en_cum_size,
                 en_trunc, init_trunc, bdi_partial_reg, bdi_complete, bdo_complete, en_state_in,
                 sel_tag, lock_tag_state, decrypt_reg, ctrl_word, key_ready, bdi_ready,
                 bdo_valid, auth_valid, auth};

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Per-operation observations gathered by the monitor
  int unsigned n_start, n_key, n_npub, n_ad_abs, n_ad_part, n_msg_abs, n_msg_part;
  int unsigned n_itrunc, n_etrunc, n_data, n_data_cmp, n_tag, n_auth, n_tag_stall;
  int unsigned exp_etrunc;
  logic [1:0]  tag_seq;
  logic        auth_val;
  int          t_start, t_ilock;
  int          cyc = 0;
  int unsigned pd_once = 0;
  bit          hold_req = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: samples on the falling edge
  initial begin
    bit prev_stall, prev_sel, prev_cmp;
    prev_stall = 0; prev_sel = 0; prev_cmp = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (start) begin
          n_start++;
          if (t_start < 0) t_start = cyc;
          check("bdi_ready_during_perm", bdi_ready, 0);
        end
        if (init_lock && t_ilock < 0) t_ilock = cyc;
        if (en_key)  n_key++;
        if (en_npub) n_npub++;
        if (en_state_in && ctrl_word == 2'b01) begin
          n_ad_abs++;
          if (bdi_partial_reg) n_ad_part++;
        end
        if (en_state_in && ctrl_word == 2'b10) begin
          n_msg_abs++;
          if (bdi_partial_reg) n_msg_part++;
        end
        if (init_trunc) n_itrunc++;
        if (en_trunc)   n_etrunc++;
        if (bdo_valid && bdo_ready) begin
          if (sel_tag) begin
            n_tag++;
            tag_seq = {tag_seq[0], bdo_complete};
          end else begin
            n_data++;
            n_data_cmp += bdo_complete;
          end
        end
        if (auth_valid) begin
          n_auth++;
          auth_val = auth;
        end
        if (prev_stall) begin
          check("bdo_valid_held", bdo_valid, 1);
          check("sel_tag_stable", sel_tag, prev_sel);
          check("bdo_complete_stable", bdo_complete, prev_cmp);
          check("no_state_en_in_stall", en_state_in, 0);
          if (sel_tag) n_tag_stall++;
        end
        prev_stall = bdo_valid && !bdo_ready;
        prev_sel   = sel_tag;
        prev_cmp   = bdo_complete;
      end else begin
        prev_stall = 0;
      end
    end
  end

  // Permutation responder: optional perm_done glitch in the start cycle, then done after d cycles
  initial begin
    int unsigned d;
    bit glitch;
    perm_done = 0;
    forever begin
      @(posedge clk); #1;
      if (start && !rst) begin
        if (pd_once != 0) begin
          d = pd_once; glitch = 1; pd_once = 0;
        end else begin
          d = $urandom_range(1, 5); glitch = 0;
        end
        perm_done = glitch;
        for (int unsigned k = 1; k <= d; k++) begin
          @(posedge clk); #1;
          perm_done = (k == d);
        end
        @(posedge clk); #1;
        perm_done = 0;
      end
    end
  end

  // Truncation responder: trunc_complete after d en_trunc cycles
  initial begin
    int unsigned d;
    trunc_complete = 0;
    forever begin
      @(posedge clk); #1;
      if (init_trunc && !rst) begin
        d = $urandom_range(1, 4);
        exp_etrunc += d;
        repeat (d) begin @(posedge clk); #1; end
        trunc_complete = 1;
        @(posedge clk); #1;
        trunc_complete = 0;
      end
    end
  end

  // bdo sink: random backpressure, or a 10-cycle hold on tag word 0 when requested
  initial begin
    bdo_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (hold_req && bdo_valid && sel_tag && !bdo_complete) begin
        bdo_ready = 0;
        repeat (10) begin @(posedge clk); #1; end
        hold_req  = 0;
        bdo_ready = 1;
      end else begin
        bdo_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic send_cmd();
    bit ok; int unsigned n;
    cmd_valid = 1; n = 0;
    do begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 300);
    cmd_valid = 0;
    if (!ok) check("cmd_handshake_timeout", 0, 1);
  endtask

  task automatic send_key();
    bit ok; int unsigned n;
    key_valid = 1; n = 0;
    do begin
      @(negedge clk); ok = key_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 300);
    key_valid = 0;
    if (!ok) check("key_handshake_timeout", 0, 1);
  endtask

  task automatic send_bdi(input logic [3:0] t, input logic [2:0] s, input bit e);
    bit ok; int unsigned n;
    bdi_type = t; bdi_size = s; bdi_eot = e; bdi_valid = 1; n = 0;
    do begin
      @(negedge clk); ok = bdi_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 300);
    bdi_valid = 0; bdi_eot = 0;
    if (!ok) check("bdi_handshake_timeout", 0, 1);
  endtask

  task automatic send_seg(input logic [3:0] t, input int unsigned len);
    int unsigned rem, sz;
    rem = len;
    while (rem > 0) begin
      sz  = (rem > 4) ? 4 : rem;
      rem = rem - sz;
      send_bdi(t, 3'(sz), rem == 0);
    end
  endtask

  task automatic clear_obs();
    n_start = 0; n_key = 0; n_npub = 0; n_ad_abs = 0; n_ad_part = 0; n_msg_abs = 0;
    n_msg_part = 0; n_itrunc = 0; n_etrunc = 0; n_data = 0; n_data_cmp = 0; n_tag = 0;
    n_auth = 0; n_tag_stall = 0; exp_etrunc = 0; tag_seq = 2'b00; auth_val = 0;
    t_start = -1; t_ilock = -1;
  endtask

  task automatic run_op(input bit dec, input bit nk, input int unsigned adlen,
                        input int unsigned msglen);
    bit ok; int unsigned n, nad, nmsg;
    clear_obs();
    dp_msg_auth   = 1'($urandom_range(0, 1));
    cmd_decrypt   = dec;
    cmd_new_key   = nk;
    cmd_empty_ad  = (adlen == 0);
    cmd_empty_msg = (msglen == 0);
    send_cmd();
    if (nk) for (int i = 0; i < 4; i++) send_key();
    for (int i = 0; i < 4; i++) send_bdi(4'b1101, 3'd4, i == 3);
    send_seg(4'b0001, adlen);
    send_seg(4'b0100, msglen);
    if (dec) for (int i = 0; i < 2; i++) send_bdi(4'b1000, 3'd4, i == 1);
    n = 0;
    do begin
      @(negedge clk); ok = cmd_ready; n++;
    end while (!ok && n < 1000);
    check("cmd_ready_after_op", ok, 1);
    @(posedge clk); #1;
    // Expected values derived from segment lengths: 8-byte blocks, 4-byte words
    nad  = (adlen + 7) / 8;
    nmsg = (msglen + 7) / 8;
    check("start_pulses", n_start, 2 + nad + nmsg);
    check("key_words", n_key, nk ? 4 : 0);
    check("npub_words", n_npub, 4);
    check("ad_absorbs", n_ad_abs, nad);
    check("ad_partial", n_ad_part, (adlen % 8 != 0) ? 1 : 0);
    check("msg_absorbs", n_msg_abs, nmsg);
    check("msg_partial", n_msg_part, (msglen % 8 != 0) ? 1 : 0);
    check("init_trunc", n_itrunc, (msglen % 8 != 0) ? 1 : 0);
    check("en_trunc_cycles", n_etrunc, exp_etrunc);
    check("bdo_data_words", n_data, (msglen + 3) / 4);
    check("bdo_data_complete", n_data_cmp, msglen / 8 + (((msglen % 8) > 4) ? 1 : 0));
    check("tag_words_out", n_tag, dec ? 0 : 2);
    if (!dec) check("tag_complete_order", tag_seq, 2'b01);
    check("auth_strobes", n_auth, dec ? 1 : 0);
    if (dec) check("auth_value", auth_val, dp_msg_auth);
    check("decrypt_reg", decrypt_reg, dec);
  endtask

  task automatic reset_mid_msg();
    bit ok; int unsigned n;
    clear_obs();
    dp_msg_auth = 1; cmd_decrypt = 1; cmd_new_key = 0; cmd_empty_ad = 1; cmd_empty_msg = 0;
    send_cmd();
    for (int i = 0; i < 4; i++) send_bdi(4'b1101, 3'd4, i == 3);
    bdi_type = 4'b0100; bdi_size = 3'd4; bdi_valid = 0; n = 0;
    do begin
      @(negedge clk); ok = bdi_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 300);
    check("reached_msg_read", ok, 1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_op_outputs", outs, 0);
    check("reset_mid_op_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    rst = 0;
    repeat (5) begin @(posedge clk); #1; end
    check("abandoned_bdo", n_data + n_tag, 0);
    check("abandoned_auth", n_auth, 0);
  endtask

  initial begin
    bit d, k;
    int unsigned a, m;
    rst = 1; cmd_valid = 0; cmd_decrypt = 0; cmd_new_key = 0; cmd_empty_ad = 0;
    cmd_empty_msg = 0; key_valid = 0; bdi_valid = 0; bdi_eot = 0; bdi_type = '0;
    bdi_size = '0; dp_msg_auth = 0;
    clear_obs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    rst = 0;

    // New key, empty AD and message, perm_done glitch in the first start cycle
    pd_once = 17;
    run_op(0, 1, 0, 0);
    check("perm_done_latency", 32'(t_ilock - t_start), 18);

    run_op(0, 0, 8, 5);
    run_op(1, 0, 0, 3);

    hold_req = 1;
    run_op(0, 0, 0, 0);
    check("tag_word0_stall_seen", (n_tag_stall >= 10) ? 1 : 0, 1);

    reset_mid_msg();
    run_op(0, 1, 3, 9);

    for (int i = 0; i < 20; i++) begin
      d = 1'($urandom_range(0, 1));
      k = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 20);
      m = $urandom_range(0, 20);
      run_op(d, k, a, m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
